bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/common_pkg.sv | 73 +++++++
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Bus types and encodings shared by the MMU, the arbiter and the memory-side cbus.
// A request on any bus is one packed struct; responses likewise.
package common_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Encoded as beats minus one, AXI style.
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

endpackage

// File: rtl/bus_arbiter.sv
// Merges the MMU instruction and data ports onto a single cbus master port,
// one single-beat transaction at a time, alternating grants on conflict.
module bus_arbiter
    import common_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    state_t    state_reg;
    logic      last_grant_reg;
    logic      grant_data_reg;
    cbus_req_t req_reg;

    logic grant_i;
    logic grant_d;
    logic done;

    function automatic cbus_req_t instr_request(input ibus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = 1'b0;
        c.size     = MSIZE4;
        c.addr     = r.addr;
        c.strobe   = '0;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    function automatic cbus_req_t data_request(input dbus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = |r.strobe;
        c.size     = r.size;
        c.addr     = r.addr;
        c.strobe   = r.strobe;
        c.data     = r.data;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    // On a conflict the data port wins only if instruction was granted last.
    always_comb begin
        grant_d = dreq.valid && (!ireq.valid || (last_grant_reg == GRANT_INSTR));
        grant_i = ireq.valid && !grant_d;
    end

    assign done = (state_reg == SERVE) && oresp.ready && oresp.last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_DATA;
            grant_data_reg <= GRANT_INSTR;
            req_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state_reg      <= SERVE;
                        last_grant_reg <= grant_d;
                        grant_data_reg <= grant_d;
                        req_reg        <= grant_d ? data_request(dreq) : instr_request(ireq);
                    end
                end
                SERVE: begin
                    // The client may have dropped valid by now; completion only waits on the cbus.
                    if (done) begin
                        state_reg <= IDLE;
                        req_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= '0;
                end
            endcase
        end
    end

    assign oreq = req_reg;

    // The response is a same-cycle pulse on the granted port; req_reg still holds the address.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (done) begin
            if (grant_data_reg == GRANT_DATA) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = oresp.data;
            end else begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = req_reg.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level model queues expected cbus
// requests and client responses; a negedge monitor pops and compares them.
module tb_bus_arbiter;
    import common_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    typedef struct {
        cbus_req_t req;
        bit        is_data;
    } exp_txn_t;

    typedef struct {
        bit          is_data;
        logic [63:0] data;
    } exp_resp_t;

    exp_txn_t  exp_txn_q[$];
    exp_resp_t exp_resp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: is a transaction outstanding, who was served last, what is owed.
    bit m_busy          = 1'b0;
    bit m_last_data     = 1'b1;
    bit m_cur_is_data   = 1'b0;
    bit m_cur_addr2     = 1'b0;
    int m_wait          = 0;
    bit model_serve_now = 1'b0;
    bit exp_pulse_now   = 1'b0;
    int n_grants        = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic ibus_req_t mk_i(input bit v, input logic [63:0] a);
        ibus_req_t r;
        r.valid = v;
        r.addr  = a;
        return r;
    endfunction

    function automatic dbus_req_t mk_d(input bit v, input logic [63:0] a, input msize_t s,
                                       input logic [7:0] st, input logic [63:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = s;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    function automatic ibus_req_t gen_i();
        logic [63:0] a;
        a = rand64();
        a[1:0] = 2'b00;
        return mk_i(($urandom % 3) != 0, a);
    endfunction

    function automatic dbus_req_t gen_d();
        logic [31:0] r;
        r = $urandom;
        return mk_d(($urandom % 3) != 0, rand64(), msize_t'(3'($urandom_range(0, 3))),
                    (($urandom % 3) == 0) ? 8'h00 : r[7:0], rand64());
    endfunction

    function automatic cbus_req_t exp_from_i(input ibus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = 1'b0;
        c.size     = MSIZE4;
        c.addr     = r.addr;
        c.strobe   = 8'h00;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    function automatic cbus_req_t exp_from_d(input dbus_req_t r);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = (r.strobe != 8'h00);
        c.size     = r.size;
        c.addr     = r.addr;
        c.strobe   = r.strobe;
        c.data     = r.data;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    // One clock cycle: drive clients and memory, record what the arbiter owes.
    task automatic step(input ibus_req_t si, input dbus_req_t sd, input int wait_cycles,
                        input logic [63:0] rd);
        bit        next_busy;
        bit        take_data;
        exp_txn_t  t;
        exp_resp_t r;
        ireq            = si;
        dreq            = sd;
        next_busy       = m_busy;
        exp_pulse_now   = 1'b0;
        model_serve_now = m_busy;
        if (!m_busy) begin
            oresp.ready = 1'($urandom);
            oresp.last  = 1'($urandom);
            oresp.data  = rand64();
            if (si.valid || sd.valid) begin
                take_data = (si.valid && sd.valid) ? !m_last_data : sd.valid;
                t.is_data = take_data;
                t.req     = take_data ? exp_from_d(sd) : exp_from_i(si);
                exp_txn_q.push_back(t);
                m_last_data   = take_data;
                m_cur_is_data = take_data;
                m_cur_addr2   = si.addr[2];
                m_wait        = wait_cycles;
                next_busy     = 1'b1;
                n_grants++;
            end
        end else if (m_wait == 0) begin
            oresp.ready = 1'b1;
            oresp.last  = 1'b1;
            oresp.data  = rd;
            r.is_data   = m_cur_is_data;
            r.data      = m_cur_is_data ? rd : {32'h0, (m_cur_addr2 ? rd[63:32] : rd[31:0])};
            exp_resp_q.push_back(r);
            exp_pulse_now = 1'b1;
            next_busy     = 1'b0;
        end else begin
            oresp.ready = 1'b0;
            oresp.last  = 1'($urandom);
            oresp.data  = rand64();
            m_wait--;
        end
        @(posedge clk);
        #1;
        m_busy = next_busy;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && m_busy; k++)
            step(mk_i(1'b0, 64'h0), mk_d(1'b0, 64'h0, MSIZE1, 8'h00, 64'h0), 0, rand64());
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        ireq            = '0;
        dreq            = '0;
        oresp           = '0;
        exp_pulse_now   = 1'b0;
        model_serve_now = 1'b0;
        exp_txn_q.delete();
        exp_resp_q.delete();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        m_busy      = 1'b0;
        m_last_data = 1'b1;
    endtask

    // Monitor
    bit       have_cur = 1'b0;
    exp_txn_t cur;

    initial begin
        exp_resp_t  r;
        ibus_resp_t ei;
        dbus_resp_t ed;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_cur = 1'b0;
            end else begin
                if (model_serve_now) begin
                    if (!have_cur) begin
                        if (exp_txn_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL oreq_queue: serving with no expected request");
                        end else begin
                            cur      = exp_txn_q.pop_front();
                            have_cur = 1'b1;
                        end
                    end
                    if (have_cur) begin
                        check("oreq.valid",    128'(oreq.valid),    128'(cur.req.valid));
                        check("oreq.is_write", 128'(oreq.is_write), 128'(cur.req.is_write));
                        check("oreq.size",     128'(oreq.size),     128'(cur.req.size));
                        check("oreq.addr",     128'(oreq.addr),     128'(cur.req.addr));
                        check("oreq.strobe",   128'(oreq.strobe),   128'(cur.req.strobe));
                        check("oreq.len",      128'(oreq.len),      128'(cur.req.len));
                        check("oreq.burst",    128'(oreq.burst),    128'(cur.req.burst));
                        if (cur.is_data)
                            check("oreq.data", 128'(oreq.data), 128'(cur.req.data));
                    end
                end else begin
                    check("oreq.valid_idle", 128'(oreq.valid), 128'(0));
                end
                if (exp_pulse_now) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_queue: pulse expected with empty queue");
                    end else begin
                        r  = exp_resp_q.pop_front();
                        ei = '0;
                        ed = '0;
                        if (r.is_data) begin
                            ed.addr_ok = 1'b1;
                            ed.data_ok = 1'b1;
                            ed.data    = r.data;
                        end else begin
                            ei.addr_ok = 1'b1;
                            ei.data_ok = 1'b1;
                            ei.data    = r.data[31:0];
                        end
                        check("iresp_pulse", 128'(iresp), 128'(ei));
                        check("dresp_pulse", 128'(dresp), 128'(ed));
                    end
                    have_cur = 1'b0;
                end else begin
                    check("iresp_quiet", 128'(iresp), 128'(0));
                    check("dresp_quiet", 128'(dresp), 128'(0));
                end
            end
        end
    end

    ibus_req_t no_i;
    dbus_req_t no_d;

    initial begin
        no_i  = mk_i(1'b0, 64'h0);
        no_d  = mk_d(1'b0, 64'h0, MSIZE1, 8'h00, 64'h0);
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_oreq",  128'(oreq),  128'(0));
        check("reset_iresp", 128'(iresp), 128'(0));
        check("reset_dresp", 128'(dresp), 128'(0));

        // Instruction fetch, upper word lane, three wait cycles.
        step(mk_i(1'b1, 64'h8000_0004), no_d, 3, 64'h1111_2222_3333_4444);
        drain();
        $display("txn ifetch addr=80000004 wait=3");

        // Data write, immediate completion.
        step(no_i, mk_d(1'b1, 64'h8000_1000, MSIZE4, 8'h0F, 64'hDEAD), 0, rand64());
        drain();
        $display("txn dwrite addr=80001000 strobe=0f");

        // Data read whose client drops valid right after the grant.
        step(no_i, mk_d(1'b1, 64'h8000_2008, MSIZE8, 8'h00, 64'h0), 4, rand64());
        drain();
        $display("txn dread with valid dropped");

        // Long stall: request must hold, no pulses.
        step(mk_i(1'b1, 64'h8000_0010), no_d, 20, rand64());
        drain();
        $display("txn ifetch stalled 20 cycles");

        // Both ports always valid right after reset: I,D,I,D.
        do_reset();
        for (int k = 0; k < 8; k++)
            step(mk_i(1'b1, 64'h8000_0100 + 64'(k * 16)),
                 mk_d(1'b1, 64'h9000_0000 + 64'(k * 8), MSIZE8, 8'hFF, rand64()), 0, rand64());
        drain();
        $display("txn conflict sequence of 4 grants");

        // Reset in the second SERVE cycle abandons the transaction.
        step(mk_i(1'b1, 64'h8000_0040), no_d, 5, rand64());
        step(no_i, no_d, 0, rand64());
        do_reset();
        step(no_i, no_d, 0, rand64());
        step(no_i, mk_d(1'b1, 64'h8000_3000, MSIZE2, 8'h03, 64'hBEEF), 1, rand64());
        drain();
        $display("txn reset mid-serve then fresh dwrite");

        // Randomised traffic.
        for (int k = 0; k < 800; k++)
            step(gen_i(), gen_d(),
                 (($urandom % 8) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3)),
                 rand64());
        drain();
        step(no_i, no_d, 0, rand64());
        $display("txn random phase done, %0d grants total", n_grants);

        check("txn_queue_empty",  128'(exp_txn_q.size()),  128'(0));
        check("resp_queue_empty", 128'(exp_resp_q.size()), 128'(0));
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
